alu_result_fifo: RTL and testbench
==================================

Name: alu_result_fifo

Overview:
Downstream stage of the 4-bit ALU. It captures each 7-bit ALU result word {sign, zero, carry, out[3:0]} and buffers it in a small FIFO, so a slower consumer can drain results with a valid/ready handshake. It also keeps sticky flag summaries and a saturating count of results dropped because the FIFO was full.

Parameters:
DEPTH, 4, number of FIFO entries; must be a power of two, 2..16.
DATA_W, 7, result word width: bit6 sign, bit5 zero, bit4 carry, bits3:0 out.
CNT_W, 8, width of the drop counter.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  producer presents a result word this cycle.
in_data  input  DATA_W  result word {sign, zero, carry, out}.
in_ready  output  1  FIFO can accept a word this cycle.
out_valid  output  1  head word is available.
out_data  output  DATA_W  head word (show-ahead).
out_ready  input  1  consumer takes the head word this cycle.
clear  input  1  synchronous clear of the sticky flags and the drop counter.
level  output  $clog2(DEPTH)+1  number of stored entries, 0..DEPTH.
carry_seen  output  1  sticky: an accepted word had carry=1.
zero_seen  output  1  sticky: an accepted word had zero=1.
sign_seen  output  1  sticky: an accepted word had sign=1.
drop_cnt  output  CNT_W  saturating count of rejected pushes.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: pointers=0, level=0, out_valid=0, in_ready=1, all sticky flags=0, drop_cnt=0. out_data is don't-care while out_valid=0; the bench must not check it then.
- Reset asserted mid-operation empties the FIFO immediately. Stored contents are discarded, and memory contents need no reset.
- Storage: DEPTH-entry array, with write pointer wr_ptr and read pointer rd_ptr, each $clog2(DEPTH) bits. Pointers wrap modulo DEPTH. Full and empty are derived from level.
- in_ready = (level != DEPTH). It is combinational from registered state only and does not depend on out_ready, so there is no pass-through when full.
- out_valid = (level != 0). out_data = mem[rd_ptr], combinational read.
- Push: in_valid & in_ready. The word is written at wr_ptr and wr_ptr increments.
- Pop: out_valid & out_ready. rd_ptr increments.
- Latency: a word pushed in cycle N is visible on out_data with out_valid=1 in cycle N+1.
- Simultaneous push and pop: both take effect and level is unchanged. This is legal at any non-full, non-empty level. When empty only the push occurs; when full only the pop occurs.
- level: +1 on push only, -1 on pop only, unchanged otherwise. It never exceeds DEPTH and never goes below 0.
- Drop: in_valid & ~in_ready increments drop_cnt by 1 per cycle. drop_cnt saturates at 2^CNT_W-1. The word is discarded.
- Sticky flags: on an accepted push, each flag ORs with the corresponding bit of in_data (bit4→carry_seen, bit5→zero_seen, bit6→sign_seen). Rejected words do not affect the flags.
- clear: the next state of the flags is 0 and drop_cnt is 0, then the same-cycle events are applied on top.
  - clear together with an accepted push leaves the flags equal to the pushed word's bits.
  - clear together with a rejected push leaves drop_cnt=1.
  - clear does not touch FIFO contents, pointers or level.
- The block has no FSM beyond the pointer/level state. No combinational path exists from in_valid to in_ready or from out_ready to out_valid.

Test Plan:
1. Reset, then push 0x11 (add 9+8: out=1, carry=1) -> next cycle out_valid=1, out_data=0x11, level=1, carry_seen=1, zero_seen=0, sign_seen=0.
2. Push 0x11, 0x20 (sub 3-3), 0x5E (sub 3-5), 0x0C (or 4|8) back-to-back with out_ready=0 -> level=4, in_ready=0, all sticky flags=1. Then drain with out_ready=1 -> order 0x11, 0x20, 0x5E, 0x0C, then out_valid=0.
3. With the FIFO full, hold in_valid=1 for 3 cycles with out_ready=0 -> drop_cnt=3, level stays 4, contents unchanged. Force 300 rejected pushes -> drop_cnt saturates at 255.
4. At level=2, assert in_valid and out_ready together for 10 cycles with incrementing data 0x00..0x09 -> level stays 2 and output order is preserved across pointer wrap-around.
5. Assert clear in the same cycle as an accepted push of 0x20 after flags=111 and drop_cnt=5 -> zero_seen=1, carry_seen=0, sign_seen=0, drop_cnt=0, level increments.
6. Drop rst_n asynchronously mid-cycle at level=3 -> out_valid=0, level=0, in_ready=1 immediately, without waiting for a clock edge. After release, the first push is read back correctly.

Source files
------------

// File: rtl/alu_result_fifo.sv
// Result buffer behind the 4-bit ALU: a show-ahead FIFO with valid/ready on both sides,
// sticky sign/zero/carry summaries of accepted words, and a saturating drop counter.
module alu_result_fifo #(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 7,
   parameter int CNT_W  = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   input  logic [DATA_W-1:0]          in_data,
   output logic                       in_ready,
   output logic                       out_valid,
   output logic [DATA_W-1:0]          out_data,
   input  logic                       out_ready,
   input  logic                       clear,
   output logic [$clog2(DEPTH):0]     level,
   output logic                       carry_seen,
   output logic                       zero_seen,
   output logic                       sign_seen,
   output logic [CNT_W-1:0]           drop_cnt
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic              push;
   logic              pop;
   logic              drop;

   // Readiness comes only from registered level, so a full FIFO never passes a word straight through.
   assign in_ready  = (level != LVL_W'(DEPTH));
   assign out_valid = (level != '0);
   assign out_data  = mem[rd_ptr];

   assign push = in_valid & in_ready;
   assign pop  = out_valid & out_ready;
   assign drop = in_valid & ~in_ready;

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= in_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   level <= level + LVL_W'(1);
            2'b01:   level <= level - LVL_W'(1);
            default: level <= level;
         endcase
      end
   end

   // Clear zeroes the summaries first; this cycle's accepted word or drop is then applied on top.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         carry_seen <= 1'b0;
         zero_seen  <= 1'b0;
         sign_seen  <= 1'b0;
         drop_cnt   <= '0;
      end else begin
         carry_seen <= (carry_seen & ~clear) | (push & in_data[4]);
         zero_seen  <= (zero_seen  & ~clear) | (push & in_data[5]);
         sign_seen  <= (sign_seen  & ~clear) | (push & in_data[6]);
         if (clear) begin
            drop_cnt <= drop ? CNT_W'(1) : '0;
         end else if (drop && (drop_cnt != {CNT_W{1'b1}})) begin
            drop_cnt <= drop_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_alu_result_fifo.sv
// Directed bench for alu_result_fifo: the driver queues each word it expects to be accepted,
// and a negedge monitor pops and compares whenever the DUT hands a word to the consumer.
module tb_alu_result_fifo;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic [6:0] in_data;
   logic       in_ready;
   logic       out_valid;
   logic [6:0] out_data;
   logic       out_ready;
   logic       clear;
   logic [2:0] level;
   logic       carry_seen;
   logic       zero_seen;
   logic       sign_seen;
   logic [7:0] drop_cnt;

   int         assert_count = 0;
   int         fail_count   = 0;
   logic [6:0] sb [$];

   alu_result_fifo #(.DEPTH(4), .DATA_W(7), .CNT_W(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_ready  (out_ready),
      .clear      (clear),
      .level      (level),
      .carry_seen (carry_seen),
      .zero_seen  (zero_seen),
      .sign_seen  (sign_seen),
      .drop_cnt   (drop_cnt)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      assert_count++;
      if (actual !== expected) begin
         fail_count++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Drives one cycle of inputs; acc states by hand whether this word should be accepted.
   task automatic applyStimulus(input logic v, input logic [6:0] d, input logic r, input logic c, input logic acc);
      in_valid  = v;
      in_data   = d;
      out_ready = r;
      clear     = c;
      if (v && acc) sb.push_back(d);
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      in_valid  = 1'b0;
      in_data   = 7'h00;
      out_ready = 1'b0;
      clear     = 1'b0;
   endtask

   task automatic checkFlags(input string name, input logic [2:0] exp_szc);
      checkOutput(name, {29'd0, sign_seen, zero_seen, carry_seen}, {29'd0, exp_szc});
   endtask

   // Consumer-side monitor: every handshake must present the oldest queued word.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         assert_count++;
         if (sb.size() == 0) begin
            fail_count++;
            $display("[TB] FAIL sb_pop: got 0x%0h, expected no word at %0t", out_data, $time);
         end else begin
            logic [6:0] exp_word;
            exp_word = sb.pop_front();
            if (out_data !== exp_word) begin
               fail_count++;
               $display("[TB] FAIL sb_data: got 0x%0h, expected 0x%0h at %0t", out_data, exp_word, $time);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst_n = 1'b0;
      idle();
      #3;
      checkOutput("rst_level", level, 0);
      checkOutput("rst_out_valid", out_valid, 0);
      checkOutput("rst_in_ready", in_ready, 1);
      checkFlags("rst_flags", 3'b000);
      checkOutput("rst_drop", drop_cnt, 0);
      #19 rst_n = 1'b1;
      @(posedge clk);
      #1;

      $display("[TB] single push");
      applyStimulus(1, 7'h11, 0, 0, 1);
      idle();
      checkOutput("t1_out_valid", out_valid, 1);
      checkOutput("t1_out_data", out_data, 7'h11);
      checkOutput("t1_level", level, 1);
      checkFlags("t1_flags", 3'b001);
      applyStimulus(0, 7'h00, 1, 0, 0);
      idle();
      checkOutput("t1_drained", level, 0);

      $display("[TB] fill to full");
      applyStimulus(1, 7'h11, 0, 0, 1);
      applyStimulus(1, 7'h20, 0, 0, 1);
      applyStimulus(1, 7'h5E, 0, 0, 1);
      applyStimulus(1, 7'h0C, 0, 0, 1);
      idle();
      checkOutput("t2_level", level, 4);
      checkOutput("t2_in_ready", in_ready, 0);
      checkFlags("t2_flags", 3'b111);

      $display("[TB] drops while full");
      for (int i = 0; i < 3; i++) applyStimulus(1, 7'h7F, 0, 0, 0);
      idle();
      checkOutput("t3_drop3", drop_cnt, 3);
      checkOutput("t3_level_full", level, 4);
      for (int i = 0; i < 4; i++) applyStimulus(0, 7'h00, 1, 0, 0);
      idle();
      checkOutput("t2_empty_valid", out_valid, 0);
      checkOutput("t2_empty_level", level, 0);
      for (int i = 1; i <= 4; i++) applyStimulus(1, 7'(i), 0, 0, 1);
      for (int i = 0; i < 300; i++) applyStimulus(1, 7'h55, 0, 0, 0);
      idle();
      checkOutput("t3_drop_sat", drop_cnt, 255);
      checkOutput("t3_level_sat", level, 4);
      for (int i = 0; i < 4; i++) applyStimulus(0, 7'h00, 1, 0, 0);
      idle();
      checkOutput("t3_drained", level, 0);

      $display("[TB] simultaneous push/pop across wrap");
      applyStimulus(1, 7'h30, 0, 0, 1);
      applyStimulus(1, 7'h31, 0, 0, 1);
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1, 7'(i), 1, 0, 1);
         checkOutput("t4_level_hold", level, 2);
      end
      applyStimulus(0, 7'h00, 1, 0, 0);
      applyStimulus(0, 7'h00, 1, 0, 0);
      idle();
      checkOutput("t4_drained", level, 0);

      $display("[TB] clear behaviour");
      applyStimulus(0, 7'h00, 0, 1, 0);
      idle();
      checkFlags("t5_clear_flags", 3'b000);
      checkOutput("t5_clear_drop", drop_cnt, 0);
      applyStimulus(1, 7'h70, 0, 0, 1);
      applyStimulus(1, 7'h01, 0, 0, 1);
      applyStimulus(1, 7'h02, 0, 0, 1);
      applyStimulus(1, 7'h03, 0, 0, 1);
      for (int i = 0; i < 5; i++) applyStimulus(1, 7'h7F, 0, 0, 0);
      idle();
      checkOutput("t5_drop5", drop_cnt, 5);
      checkFlags("t5_flags111", 3'b111);
      applyStimulus(0, 7'h00, 1, 0, 0);
      idle();
      checkOutput("t5_level3", level, 3);
      applyStimulus(1, 7'h20, 0, 1, 1);
      idle();
      checkFlags("t5_clear_push_flags", 3'b010);
      checkOutput("t5_clear_push_drop", drop_cnt, 0);
      checkOutput("t5_clear_push_level", level, 4);
      applyStimulus(1, 7'h7F, 0, 1, 0);
      idle();
      checkOutput("t5_clear_drop_one", drop_cnt, 1);
      checkOutput("t5_clear_keeps_level", level, 4);

      $display("[TB] asynchronous reset");
      applyStimulus(0, 7'h00, 1, 0, 0);
      idle();
      checkOutput("t6_level3", level, 3);
      #2;
      rst_n = 1'b0;
      sb.delete();
      #1;
      checkOutput("t6_async_valid", out_valid, 0);
      checkOutput("t6_async_level", level, 0);
      checkOutput("t6_async_ready", in_ready, 1);
      checkOutput("t6_async_drop", drop_cnt, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      applyStimulus(1, 7'h2A, 0, 0, 1);
      idle();
      checkOutput("t6_post_valid", out_valid, 1);
      checkOutput("t6_post_data", out_data, 7'h2A);
      checkOutput("t6_post_level", level, 1);
      applyStimulus(0, 7'h00, 1, 0, 0);
      idle();
      checkOutput("t6_post_drained", level, 0);
      checkOutput("sb_empty", sb.size(), 0);

      $display("[TB] End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
      $finish;
   end

endmodule
